wtm_pipe: RTL
=============

// Module: wtm_pipe
// PURPOSE
//  Parametrised, pipelined Wallace-tree multiplier; successor to the fixed 5x5 combinational wtm.
//  Accepts one operand pair per cycle over a valid/ready handshake and returns the 2*WIDTH-bit product PIPE_STAGES+1 cycles later.
//  Supports a per-transaction signed/unsigned mode and reports WIDTH-bit truncation overflow.
//  Sits between the operand issue logic and the result writeback in the datapath.
// PARAMETERS
//  WIDTH        5  operand width in bits (>=2); product is 2*WIDTH bits
//  PIPE_STAGES  2  register stages inside the reduction tree (0..number of CSA levels); final CPA always registered
// PORTS
//  clock      in   1          rising-edge clock
//  reset_n    in   1          synchronous active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block can accept operands this cycle
//  in1        in   WIDTH      multiplicand
//  in2        in   WIDTH      multiplier
//  is_signed  in   1          1: two's-complement operands (Baugh-Wooley); 0: unsigned
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result this cycle
//  result     out  2*WIDTH    product
//  ovf        out  1          product does not fit in WIDTH bits under the selected mode
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-low.
//  - Reset: on a clock edge with reset_n=0, every stage valid bit clears and out_valid=0, result=0, ovf=0.
//    in_ready=1 from the first cycle after reset deasserts. In-flight data is discarded, not flushed out.
//  - Accept: a transfer occurs when in_valid & in_ready at a rising edge. Output handshake: out_valid & out_ready.
//  - Latency: result appears with out_valid=1 exactly PIPE_STAGES+1 cycles after accept, when there is no stall.
//    Throughput is 1 per cycle.
//  - Stall: stall = out_valid & ~out_ready. While stalled:
//    - all pipeline registers hold;
//    - in_ready=0, driven combinationally from stall;
//    - result and ovf stay stable.
//  - Bubbles: empty stages advance normally, with no bubble collapsing.
//  - Simultaneous events: output handshake and input accept in the same cycle are legal. The pipeline advances by one stage.
//  - Modes:
//    - unsigned: result = in1*in2 (zero-extended); ovf = |result[2*WIDTH-1:WIDTH].
//    - signed: result = $signed(in1)*$signed(in2); ovf = result[2*WIDTH-1:WIDTH-1] not all-equal.
//    - is_signed travels with its operands down the pipe; mixed modes back-to-back are legal.
//  - Arithmetic:
//    - partial products are AND terms, with Baugh-Wooley inversion of the MSB row/column plus the constant correction in signed mode;
//    - 3:2 CSA levels reduce to two rows, then a single 2*WIDTH carry-propagate adder; the carry out of bit 2*WIDTH-1 is dropped;
//    - the result is exact modulo 2^(2*WIDTH).
//  - Stage placement: CSA levels are split as evenly as possible across PIPE_STAGES register boundaries.
//    The earliest stages take the extra level. Output register after the CPA.
//  - Outputs are X-free while out_valid=0 (hold last value, or 0 after reset).
// STRUCTURE
//  - Package wtm_pkg:
//    - function wtm_levels(n), the CSA level count for n rows;
//    - typedef for a {valid, is_signed, sum row, carry row} stage record.
//  - Sub-module wtm_csa_row: one parametrised row of full adders (3 vectors -> sum, carry<<1).
//    Instantiated per level via generate.
//  - Top: partial-product generator, generate-built reduction levels with optional stage registers, CPA, output register, stall logic.
// TESTING  (WIDTH=5, PIPE_STAGES=2 unless noted; out_ready=1 unless noted)
//  1. unsigned in1=5'b10010, in2=5'b00010 -> after 3 cycles result=10'h024, ovf=1 (36>31).
//  2. unsigned 18*3 then signed -3*5 (5'h1D, 5'h05) on consecutive cycles:
//     result=10'h036, ovf=1, then result=10'h3F1, ovf=0 (-15 fits 5b signed), on consecutive cycles.
//  3. Corners: unsigned 31*31 -> 10'h3C1, ovf=1; signed -16*-16 -> 10'h100, ovf=1; signed -16*1 -> 10'h3F0, ovf=0; 0*x -> 0, ovf=0.
//  4. Backpressure: stream 4 ops, hold out_ready=0 for 5 cycles.
//     -> in_ready=0, result stable while stalled; all 4 results emerge in order, none lost or duplicated.
//  5. reset_n=0 for one cycle with 2 ops in flight -> out_valid=0, result=0 next cycle; no stale result ever appears.
//  6. Random sweep for WIDTH in {2,5,8,16}, PIPE_STAGES in {0,1,max}, random valid/ready:
//     every output matches a reference-model queue (product and ovf).

Source files
------------

// File: rtl/wtm_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Wallace-tree multiplier.
package wtm_pkg;

  typedef struct packed {
    logic valid;
    logic is_signed;
  } wtm_ctl_t;

  // Rows left after lvl levels of 3:2 compression starting from n rows.
  function automatic int wtm_rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) begin
      r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  function automatic int wtm_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      l = l + 1;
    end
    return l;
  endfunction

  // True when a stage register follows level 'done'; earlier stages absorb the remainder.
  function automatic bit wtm_is_boundary(input int levels, input int stages, input int done);
    int base;
    int extra;
    int cum;
    bit hit;
    hit = 1'b0;
    if (stages > 0) begin
      base  = levels / stages;
      extra = levels % stages;
      cum   = 0;
      for (int k = 1; k <= stages; k++) begin
        cum = cum + base + ((k <= extra) ? 1 : 0);
        if (cum == done) begin
          hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/wtm_csa_row.sv
// One row of full adders: three addends in, sum row and left-shifted carry row out.
module wtm_csa_row #(
  parameter int W = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o = a_i ^ b_i ^ c_i;

  // The carry out of the top bit falls off: arithmetic is modulo 2^W.
  assign carry_o = {(a_i[W-2:0] & b_i[W-2:0]) |
                    (a_i[W-2:0] & c_i[W-2:0]) |
                    (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/wtm_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready handshake, signed (Baugh-Wooley)
// or unsigned mode per operand pair, and WIDTH-bit truncation overflow flag.
module wtm_pipe
  import wtm_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int R0 = WIDTH + 1;           // WIDTH partial-product rows plus the correction row
  localparam int LV = wtm_levels(R0);

  logic          stall_s;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] result_q, result_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] sum_s;
  logic          ovf_s;

  assign stall_s  = out_valid_q & ~out_ready;
  assign in_ready = ~stall_s;

  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic [PW-1:0] rows [R0];
    wtm_ctl_t      ctl;

    if (l == 0) begin : g_pp
      // Partial products; signed mode inverts the MSB row/column and adds 2^WIDTH + 2^(PW-1).
      always_comb begin
        for (int i = 0; i < R0; i++) begin
          rows[i] = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
          for (int j = 0; j < WIDTH; j++) begin
            rows[i][i+j] = (in1[j] & in2[i]) ^
                           (is_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
          end
        end
        rows[WIDTH][WIDTH] = is_signed;
        rows[WIDTH][PW-1]  = is_signed;
      end
      assign ctl = {in_valid & in_ready, is_signed};
    end else begin : g_red
      localparam int RIN  = wtm_rows_at(R0, l - 1);
      localparam int NG   = RIN / 3;
      localparam int ROUT = wtm_rows_at(R0, l);
      logic [PW-1:0] c_rows [R0];

      for (genvar g = 0; g < NG; g++) begin : g_csa
        wtm_csa_row #(.W(PW)) u_csa (
          .a_i     (g_lvl[l-1].rows[3*g]),
          .b_i     (g_lvl[l-1].rows[3*g+1]),
          .c_i     (g_lvl[l-1].rows[3*g+2]),
          .sum_o   (c_rows[2*g]),
          .carry_o (c_rows[2*g+1])
        );
      end

      // Rows not forming a full triple pass straight through to the next level.
      for (genvar k = 2 * NG; k < R0; k++) begin : g_pass
        if (k < ROUT) begin : g_fwd
          assign c_rows[k] = g_lvl[l-1].rows[k+NG];
        end else begin : g_zero
          assign c_rows[k] = '0;
        end
      end

      if (wtm_is_boundary(LV, PIPE_STAGES, l)) begin : g_reg
        // Stage register: holds while the output is stalled, clears on reset.
        always_ff @(posedge clock) begin
          if (!reset_n) begin
            ctl <= '0;
            for (int k = 0; k < R0; k++) begin
              rows[k] <= '0;
            end
          end else if (!stall_s) begin
            ctl <= g_lvl[l-1].ctl;
            for (int k = 0; k < R0; k++) begin
              rows[k] <= c_rows[k];
            end
          end
        end
      end else begin : g_thru
        assign rows = c_rows;
        assign ctl  = g_lvl[l-1].ctl;
      end
    end
  end

  assign sum_s = g_lvl[LV].rows[0] + g_lvl[LV].rows[1];

  // Overflow: upper half must be a pure extension of the low WIDTH bits.
  always_comb begin
    if (g_lvl[LV].ctl.is_signed) begin
      ovf_s = ~((&sum_s[PW-1:WIDTH-1]) | ~(|sum_s[PW-1:WIDTH-1]));
    end else begin
      ovf_s = |sum_s[PW-1:WIDTH];
    end
  end

  // Output register next state: bubbles clear valid but keep the last result.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    if (!stall_s) begin
      out_valid_d = g_lvl[LV].ctl.valid;
      if (g_lvl[LV].ctl.valid) begin
        result_d = sum_s;
        ovf_d    = ovf_s;
      end else begin
        result_d = result_q;
        ovf_d    = ovf_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule
